dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive load grants that may bypass a waiting store before the store is forced.
REQ-002 Parameter ROB_ID_SIZE, default rv32i_types::ROB_ID_SIZE, is the ROB tag width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-low (0 = reset).
REQ-005 flush  in  1  pipeline flush; kills uncommitted loads.
REQ-006 ld_valid / ld_rob_id / ld_addr / ld_rmask  in  1/ROB_ID_SIZE/32/4  load request from the load reservation station.
REQ-007 ld_grant  out  1  one-cycle pulse: load request accepted.
REQ-008 ld_resp_valid / ld_resp_rob_id / ld_resp_rdata  out  1/ROB_ID_SIZE/32  load completion.
REQ-009 st_valid / st_addr / st_wmask / st_wdata / st_full  in  1/32/4/32/1  committed-store request from the store-buffer head, plus the store-buffer-full flag.
REQ-010 st_grant  out  1  one-cycle pulse: store accepted.
REQ-011 st_done  out  1  one-cycle pulse: store written.
REQ-012 dmem_addr / dmem_rmask / dmem_wmask / dmem_wdata  out  32/4/4/32  data-cache request.
REQ-013 dmem_rdata / dmem_resp  in  32/1  data-cache response.

Function
REQ-014 The FSM states SHALL be IDLE, LOAD_WAIT and STORE_WAIT.
REQ-015 In IDLE, with no request, dmem_rmask and dmem_wmask SHALL be 0.
REQ-016 Arbitration SHALL be evaluated only in IDLE, and SHALL grant the store when st_valid and (st_full or starve_cnt >= STARVE_LIMIT or !ld_valid); otherwise it SHALL grant the load if ld_valid and !flush.
REQ-017 The grant pulse (ld_grant/st_grant) SHALL assert in the same IDLE cycle as the grant; request fields SHALL be captured into registers and the FSM SHALL move to LOAD_WAIT/STORE_WAIT.
REQ-018 The dmem_* request SHALL be driven from the captured registers starting the cycle after the grant and SHALL be held stable until the dmem_resp cycle inclusive.
REQ-019 The captured address SHALL be 4-byte aligned (addr[1:0] forced to 0); masks SHALL pass through unchanged.
REQ-020 On dmem_resp in LOAD_WAIT, the FSM SHALL return to IDLE; if the load is not killed, ld_resp_valid SHALL pulse the next cycle with the captured rob_id and the registered dmem_rdata.
REQ-021 On dmem_resp in STORE_WAIT, the FSM SHALL return to IDLE and st_done SHALL pulse the next cycle.
REQ-022 Minimum spacing is one IDLE cycle between transactions: no grant SHALL occur in a dmem_resp cycle.
REQ-023 flush in LOAD_WAIT, including the dmem_resp cycle, SHALL set a kill flag.
REQ-024 A killed load SHALL still hold its request until dmem_resp (the cache cannot abort) and SHALL suppress ld_resp_valid.
REQ-025 flush SHALL NOT affect stores in STORE_WAIT or a store granted the same cycle.
REQ-026 starve_cnt (3-bit, saturating) SHALL increment on each ld_grant while st_valid=1, and SHALL clear on st_grant.
REQ-027 dmem_resp in IDLE SHALL be ignored.

Reset
REQ-028 On rst=0 at a clock edge, the FSM SHALL enter IDLE from any state, including mid-transaction.
REQ-029 On reset, starve_cnt, the kill flag, all grant/resp/done outputs and both dmem masks SHALL be 0 the following cycle.
REQ-030 On reset, dmem_addr and dmem_wdata SHALL be 0.

Structure
REQ-031 A dmem_arb_state_t enum (IDLE, LOAD_WAIT, STORE_WAIT) SHALL be added to package cache_types alongside arbiter_states.
REQ-032 STARVE_LIMIT SHALL remain a module parameter.
REQ-033 There SHALL be no sub-modules; the FSM, capture registers and starve counter are flat.

Verification
REQ-034 Bench SHALL cover a load only: ld_valid, addr 0x1003, rmask 4'b0001, rob_id 5, cache resp 2 cycles later with rdata 0xDEADBEEF -> dmem_addr 0x1000, then ld_resp_valid with rob_id 5 and data 0xDEADBEEF the cycle after resp.
REQ-035 Bench SHALL cover a simultaneous request with st_full=0 and starve_cnt=0 -> load granted first; store granted in the IDLE cycle after the load's resp; st_done one cycle after the store's resp.
REQ-036 Bench SHALL cover starvation: ld_valid and st_valid held, STARVE_LIMIT=4 -> four load grants, then st_grant; starve_cnt reads 0 afterward.
REQ-037 Bench SHALL cover st_full=1 with ld_valid=1 -> immediate st_grant, wmask 4'b1111 and wdata 0x12345678 held until resp.
REQ-038 Bench SHALL cover flush: flush in the second LOAD_WAIT cycle -> request held until resp; no ld_resp_valid; next grant proceeds normally.
REQ-039 Bench SHALL cover reset in STORE_WAIT: rst=0 for 1 cycle -> next cycle IDLE with dmem_wmask 0 and no st_done; a subsequent dmem_resp is ignored.

Source files
------------

// File: rtl/cache_types.sv
// State encodings for the memory-side arbiters.
package cache_types;

    // Instruction/data cache arbiter in front of the shared memory port.
    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ICACHE,
        ARB_DCACHE
    } arbiter_states;

    // Load/store arbiter in front of the data cache.
    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        STORE_WAIT
    } dmem_arb_state_t;

endpackage

// File: rtl/rv32i_types.sv
// Core-wide type constants shared by the pipeline and memory-side blocks.
package rv32i_types;

    localparam int ROB_ID_SIZE = 5;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates load-RS requests and committed stores onto the single data-cache port,
// with a starvation counter that forces a waiting store after STARVE_LIMIT load grants.
module dmem_arbiter
    import cache_types::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ROB_ID_SIZE  = rv32i_types::ROB_ID_SIZE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,

    input  logic                   ld_valid,
    input  logic [ROB_ID_SIZE-1:0] ld_rob_id,
    input  logic [31:0]            ld_addr,
    input  logic [3:0]             ld_rmask,
    output logic                   ld_grant,
    output logic                   ld_resp_valid,
    output logic [ROB_ID_SIZE-1:0] ld_resp_rob_id,
    output logic [31:0]            ld_resp_rdata,

    input  logic                   st_valid,
    input  logic [31:0]            st_addr,
    input  logic [3:0]             st_wmask,
    input  logic [31:0]            st_wdata,
    input  logic                   st_full,
    output logic                   st_grant,
    output logic                   st_done,

    output logic [31:0]            dmem_addr,
    output logic [3:0]             dmem_rmask,
    output logic [3:0]             dmem_wmask,
    output logic [31:0]            dmem_wdata,
    input  logic [31:0]            dmem_rdata,
    input  logic                   dmem_resp
);

    dmem_arb_state_t        state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [3:0]             rmask_q, rmask_d;
    logic [3:0]             wmask_q, wmask_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [ROB_ID_SIZE-1:0] rob_q, rob_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   kill_q, kill_d;
    logic [2:0]             starve_q, starve_d;
    logic                   ld_resp_valid_q, ld_resp_valid_d;
    logic                   st_done_q, st_done_d;
    logic                   st_pick;

    // Grants are Mealy pulses in the arbitration cycle; nothing is granted while reset is held.
    always_comb begin
        st_pick  = st_valid && (st_full || (int'(starve_q) >= STARVE_LIMIT) || !ld_valid);
        st_grant = rst && (state_q == IDLE) && st_pick;
        ld_grant = rst && (state_q == IDLE) && !st_pick && ld_valid && !flush;
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no path leaves it unassigned and infers a latch.
        state_d         = state_q;
        addr_d          = addr_q;
        rmask_d         = rmask_q;
        wmask_d         = wmask_q;
        wdata_d         = wdata_q;
        rob_d           = rob_q;
        rdata_d         = rdata_q;
        kill_d          = kill_q;
        ld_resp_valid_d = 1'b0;
        st_done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (st_grant) begin
                    state_d = STORE_WAIT;
                    addr_d  = st_addr & ~32'h3;
                    rmask_d = 4'b0000;
                    wmask_d = st_wmask;
                    wdata_d = st_wdata;
                end else if (ld_grant) begin
                    state_d = LOAD_WAIT;
                    addr_d  = ld_addr & ~32'h3;
                    rmask_d = ld_rmask;
                    wmask_d = 4'b0000;
                    rob_d   = ld_rob_id;
                    kill_d  = 1'b0;
                end
            end
            LOAD_WAIT: begin
                // The cache cannot abort, so a flushed load keeps its request and only loses its response.
                if (flush) kill_d = 1'b1;
                if (dmem_resp) begin
                    state_d         = IDLE;
                    rmask_d         = 4'b0000;
                    rdata_d         = dmem_rdata;
                    ld_resp_valid_d = !(kill_q || flush);
                end
            end
            STORE_WAIT: begin
                if (dmem_resp) begin
                    state_d   = IDLE;
                    wmask_d   = 4'b0000;
                    st_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        starve_d = starve_q;
        if (st_grant)
            starve_d = 3'd0;
        else if (ld_grant && st_valid && (starve_q != 3'd7))
            starve_d = starve_q + 3'd1;
    end

    // NOTE: reset is synchronous and clears the data registers too, so the cache port reads all-zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
            state_q         <= IDLE;
            addr_q          <= '0;
            rmask_q         <= '0;
            wmask_q         <= '0;
            wdata_q         <= '0;
            rob_q           <= '0;
            rdata_q         <= '0;
            kill_q          <= 1'b0;
            starve_q        <= '0;
            ld_resp_valid_q <= 1'b0;
            st_done_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rmask_q         <= rmask_d;
            wmask_q         <= wmask_d;
            wdata_q         <= wdata_d;
            rob_q           <= rob_d;
            rdata_q         <= rdata_d;
            kill_q          <= kill_d;
            starve_q        <= starve_d;
            ld_resp_valid_q <= ld_resp_valid_d;
            st_done_q       <= st_done_d;
        end
    end

    assign dmem_addr      = addr_q;
    assign dmem_rmask     = rmask_q;
    assign dmem_wmask     = wmask_q;
    assign dmem_wdata     = wdata_q;
    assign ld_resp_valid  = ld_resp_valid_q;
    assign ld_resp_rob_id = rob_q;
    assign ld_resp_rdata  = rdata_q;
    assign st_done        = st_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
    import rv32i_types::*;

    localparam int LIMIT = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   ld_valid;
    logic [ROB_ID_SIZE-1:0] ld_rob_id;
    logic [31:0]            ld_addr;
    logic [3:0]             ld_rmask;
    logic                   ld_grant;
    logic                   ld_resp_valid;
    logic [ROB_ID_SIZE-1:0] ld_resp_rob_id;
    logic [31:0]            ld_resp_rdata;
    logic                   st_valid;
    logic [31:0]            st_addr;
    logic [3:0]             st_wmask;
    logic [31:0]            st_wdata;
    logic                   st_full;
    logic                   st_grant;
    logic                   st_done;
    logic [31:0]            dmem_addr;
    logic [3:0]             dmem_rmask;
    logic [3:0]             dmem_wmask;
    logic [31:0]            dmem_wdata;
    logic [31:0]            dmem_rdata;
    logic                   dmem_resp;

    int n_tests = 0;
    int n_fail  = 0;
    int starve  = 0;   // model: consecutive load grants taken while a store waited

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_valid(ld_valid), .ld_rob_id(ld_rob_id), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
        .ld_grant(ld_grant), .ld_resp_valid(ld_resp_valid), .ld_resp_rob_id(ld_resp_rob_id),
        .ld_resp_rdata(ld_resp_rdata),
        .st_valid(st_valid), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata),
        .st_full(st_full), .st_grant(st_grant), .st_done(st_done),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 1'b0; ld_valid = 1'b0; st_valid = 1'b0; st_full = 1'b0; dmem_resp = 1'b0;
    endtask

    // One arbitration cycle from IDLE plus, if granted, the whole wait and the response cycle.
    // fcyc selects the wait cycle (1..lat) carrying flush; 0 means none.
    task automatic do_txn(input string tag, input logic lv, input logic sv, input logic sf,
                          input logic fl0, input int lat, input int fcyc,
                          input logic [ROB_ID_SIZE-1:0] rob, input logic [31:0] la,
                          input logic [3:0] rm, input logic [31:0] sa, input logic [3:0] wm,
                          input logic [31:0] wd, input logic [31:0] rd);
        logic exp_st, exp_ld, killed;
        logic [31:0] exp_addr;
        ld_valid = lv; ld_rob_id = rob; ld_addr = la; ld_rmask = rm;
        st_valid = sv; st_full = sf; st_addr = sa; st_wmask = wm; st_wdata = wd;
        flush = fl0; dmem_resp = 1'b0;
        #1;
        exp_st = sv && (sf || starve >= LIMIT || !lv);
        exp_ld = !exp_st && lv && !fl0;
        check({tag, ".st_grant"}, 32'(st_grant), 32'(exp_st));
        check({tag, ".ld_grant"}, 32'(ld_grant), 32'(exp_ld));
        check({tag, ".idle_rmask"}, 32'(dmem_rmask), 32'h0);
        check({tag, ".idle_wmask"}, 32'(dmem_wmask), 32'h0);
        if (exp_st) starve = 0;
        else if (exp_ld && sv) starve = (starve >= 7) ? 7 : starve + 1;

        if (!exp_st && !exp_ld) begin
            tick();
            clear_inputs();
        end else begin
            killed   = 1'b0;
            exp_addr = (exp_st ? sa : la) & ~32'h3;
            for (int c = 1; c <= lat; c++) begin
                tick();
                flush      = (c == fcyc);
                dmem_resp  = (c == lat);
                dmem_rdata = (c == lat) ? rd : $urandom;
                #1;
                if (flush && exp_ld) killed = 1'b1;
                check({tag, ".addr"},  dmem_addr, exp_addr);
                check({tag, ".rmask"}, 32'(dmem_rmask), exp_ld ? 32'(rm) : 32'h0);
                check({tag, ".wmask"}, 32'(dmem_wmask), exp_st ? 32'(wm) : 32'h0);
                if (exp_st) check({tag, ".wdata"}, dmem_wdata, wd);
                check({tag, ".wait_grant"}, 32'({ld_grant, st_grant}), 32'h0);
                check({tag, ".wait_pulse"}, 32'({ld_resp_valid, st_done}), 32'h0);
            end
            tick();
            clear_inputs();
            #1;
            check({tag, ".ld_resp_valid"}, 32'(ld_resp_valid), 32'(exp_ld && !killed));
            if (exp_ld && !killed) begin
                check({tag, ".ld_resp_rob_id"}, 32'(ld_resp_rob_id), 32'(rob));
                check({tag, ".ld_resp_rdata"}, ld_resp_rdata, rd);
            end
            check({tag, ".st_done"}, 32'(st_done), 32'(exp_st));
            check({tag, ".after_masks"}, 32'({dmem_rmask, dmem_wmask}), 32'h0);
        end
    endtask

    initial begin
        rst = 1'b0;
        ld_rob_id = '0; ld_addr = '0; ld_rmask = '0;
        st_addr = '0; st_wmask = '0; st_wdata = '0; dmem_rdata = '0;
        clear_inputs();
        tick();
        tick();
        check("reset.grants", 32'({ld_grant, st_grant}), 32'h0);
        check("reset.pulses", 32'({ld_resp_valid, st_done}), 32'h0);
        check("reset.masks",  32'({dmem_rmask, dmem_wmask}), 32'h0);
        check("reset.addr",   dmem_addr, 32'h0);
        check("reset.wdata",  dmem_wdata, 32'h0);
        rst = 1'b1;
        tick();

        // Load only, unaligned address, response two cycles after grant.
        do_txn("load_only", 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, ROB_ID_SIZE'(5), 32'h0000_1003, 4'b0001,
               32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF);

        // Simultaneous request: load first, then store in the IDLE cycle after the load response.
        do_txn("simul_ld", 1'b1, 1'b1, 1'b0, 1'b0, 2, 0, ROB_ID_SIZE'(3), 32'h0000_2000, 4'b1111,
               32'h0000_3002, 4'b0011, 32'hCAFE_0001, 32'h1111_2222);
        do_txn("simul_st", 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, ROB_ID_SIZE'(3), 32'h0000_2000, 4'b1111,
               32'h0000_3002, 4'b0011, 32'hCAFE_0001, 32'h0);

        // Starvation: four loads bypass the store, the fifth arbitration forces it, then loads win again.
        for (int i = 0; i < 6; i++)
            do_txn($sformatf("starve%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, ROB_ID_SIZE'(i),
                   32'h0000_4000 + 32'(i * 4), 4'b1111, 32'h0000_5000, 4'b1111, 32'h5555_0000 + 32'(i),
                   32'hA000_0000 + 32'(i));

        // Store-buffer full overrides a waiting load.
        do_txn("st_full", 1'b1, 1'b1, 1'b1, 1'b0, 3, 0, ROB_ID_SIZE'(7), 32'h0000_6000, 4'b0001,
               32'h0000_7001, 4'b1111, 32'h1234_5678, 32'h0);

        // Flush in the second LOAD_WAIT cycle, then an ordinary load.
        do_txn("flush_ld", 1'b1, 1'b0, 1'b0, 1'b0, 3, 2, ROB_ID_SIZE'(9), 32'h0000_8000, 4'b0110,
               32'h0, 4'h0, 32'h0, 32'hBAD0_BAD0);
        do_txn("post_flush", 1'b1, 1'b0, 1'b0, 1'b0, 2, 0, ROB_ID_SIZE'(10), 32'h0000_8004, 4'b1100,
               32'h0, 4'h0, 32'h0, 32'h600D_600D);

        // Flush on the arbitration cycle blocks the load but not a store.
        do_txn("flush_idle_ld", 1'b1, 1'b0, 1'b0, 1'b1, 2, 0, ROB_ID_SIZE'(1), 32'h0000_9000, 4'b1111,
               32'h0, 4'h0, 32'h0, 32'h0);
        do_txn("flush_idle_st", 1'b0, 1'b1, 1'b0, 1'b1, 2, 1, ROB_ID_SIZE'(1), 32'h0, 4'h0,
               32'h0000_9100, 4'b1010, 32'h7777_8888, 32'h0);

        // Response while IDLE is ignored.
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_resp = 1'b0;
        #1;
        check("idle_resp.pulses", 32'({ld_resp_valid, st_done}), 32'h0);
        check("idle_resp.masks",  32'({dmem_rmask, dmem_wmask}), 32'h0);

        // Reset while in STORE_WAIT.
        st_valid = 1'b1; st_addr = 32'h0000_A00C; st_wmask = 4'b1111; st_wdata = 32'hABCD_EF01;
        #1;
        check("rst_st.grant", 32'(st_grant), 32'h1);
        starve = 0;
        tick();
        st_valid = 1'b0;
        #1;
        check("rst_st.wmask_busy", 32'(dmem_wmask), 32'hF);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rst_st.wmask",  32'(dmem_wmask), 32'h0);
        check("rst_st.done",   32'(st_done), 32'h0);
        check("rst_st.addr",   dmem_addr, 32'h0);
        check("rst_st.wdata",  dmem_wdata, 32'h0);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        #1;
        check("rst_st.late_resp", 32'({st_done, ld_resp_valid}), 32'h0);
        check("rst_st.idle_masks", 32'({dmem_rmask, dmem_wmask}), 32'h0);
        starve = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            automatic int lat = int'($urandom_range(1, 4));
            automatic int fc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : 0;
            do_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), lat, fc,
                   ROB_ID_SIZE'($urandom), $urandom, 4'($urandom), $urandom, 4'($urandom),
                   $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
